// File: rtl/fifo_pkg.sv
// Shared defaults for the flip-flop FIFO.
package fifo_pkg;

   localparam int unsigned FIFO_BITS  = 32;
   localparam int unsigned FIFO_DEPTH = 16;

endpackage : fifo_pkg

// File: rtl/fifo_reg.sv
// One storage entry: bits-wide register with load enable and async active-low clear.
module fifo_reg
   import fifo_pkg::*;
#(
   parameter int unsigned bits = FIFO_BITS
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [bits-1:0] d,
   output logic [bits-1:0] q
);

   logic [bits-1:0] data_q;
   logic [bits-1:0] data_d;

   // Load new word only when this entry is the write target.
   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = d;
      end
   end

   // Entry register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : fifo_reg

// File: rtl/flop_fifo.sv
// First-word-fall-through FIFO built from flip-flops; pointers wrap modulo depth.
module flop_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned bits  = FIFO_BITS,
   parameter int unsigned depth = FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [bits-1:0] Din,
   input  logic            push,
   input  logic            pop,
   output logic [bits-1:0] Dout,
   output logic            full,
   output logic            pndng
);

   localparam int unsigned PTR_W = $clog2(depth);
   localparam int unsigned CNT_W = $clog2(depth + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;
   logic [depth-1:0] wr_en;
   logic [bits-1:0]  mem_q [depth];

   // Status decode, handshake acceptance and next pointer/counter state.
   always_comb begin
      full     = (cnt_q == CNT_W'(depth));
      pndng    = (cnt_q != '0);
      push_ok  = push && (!full || pop);
      pop_ok   = pop && pndng;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(depth - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(depth - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // One-hot write enable for the entry addressed by the write pointer.
   always_comb begin
      wr_en = '0;
      for (int unsigned i = 0; i < depth; i++) begin
         wr_en[i] = push_ok && (wr_ptr_q == PTR_W'(i));
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar g = 0; g < depth; g++) begin : g_mem
      fifo_reg #(
         .bits (bits)
      ) u_reg (
         .clk   (clk),
         .rst_n (rst),
         .en    (wr_en[g]),
         .d     (Din),
         .q     (mem_q[g])
      );
   end

   // Head word falls through; zero while empty.
   always_comb begin
      Dout = '0;
      if (pndng) begin
         Dout = mem_q[rd_ptr_q];
      end
   end

endmodule : flop_fifo

// File: tb/tb_flop_fifo.sv
// Directed vector bench for flop_fifo (bits=32, depth=16).
module tb_flop_fifo;

   localparam int unsigned BITS  = 32;
   localparam int unsigned DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            push;
   logic            pop;
   logic [BITS-1:0] din;
   logic [BITS-1:0] dout;
   logic            full;
   logic            pndng;

   typedef struct {
      logic            push;
      logic            pop;
      logic [BITS-1:0] din;
      logic [BITS-1:0] dout;
      logic            full;
      logic            pndng;
      string           name;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   flop_fifo #(
      .bits  (BITS),
      .depth (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .Din   (din),
      .push  (push),
      .pop   (pop),
      .Dout  (dout),
      .full  (full),
      .pndng (pndng)
   );

   task automatic add(input logic pu, input logic po, input logic [BITS-1:0] d,
                      input logic [BITS-1:0] ed, input logic ef, input logic ep,
                      input string nm);
      vec_t v;
      v.push = pu; v.pop = po; v.din = d;
      v.dout = ed; v.full = ef; v.pndng = ep; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [BITS-1:0] ed,
                        input logic ef, input logic ep);
      n_vec++;
      if (dout !== ed || full !== ef || pndng !== ep) begin
         n_err++;
         $display("FAIL %s: got Dout=%h full=%b pndng=%b, want Dout=%h full=%b pndng=%b",
                  nm, dout, full, pndng, ed, ef, ep);
      end
   endtask

   task automatic step(input logic pu, input logic po, input logic [BITS-1:0] d);
      @(negedge clk);
      push = pu; pop = po; din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
      #2 rst = 1'b0;
      #1 check("reset_initial", '0, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      // Underflow, then push/pop on empty
      add(0, 1, 32'h0,  32'h0, 0, 0, "pop_empty");
      add(1, 0, 32'd7,  32'd7, 0, 1, "push7");
      add(0, 1, 32'h0,  32'h0, 0, 0, "pop7");
      add(1, 1, 32'd5,  32'd5, 0, 1, "pushpop_empty");
      add(0, 1, 32'h0,  32'h0, 0, 0, "pop5");
      // Fill 1..16, overflow push, drain
      for (int k = 1; k <= 16; k++) add(1, 0, 32'(k), 32'd1, (k == 16), 1, "fill");
      add(1, 0, 32'hDEAD, 32'd1, 1, 1, "overflow");
      for (int j = 1; j <= 16; j++)
         add(0, 1, 32'h0, (j < 16) ? 32'(j + 1) : 32'h0, 0, (j < 16), "drain");
      // Fill again, simultaneous push/pop while full
      for (int k = 1; k <= 16; k++) add(1, 0, 32'(k), 32'd1, (k == 16), 1, "refill");
      add(1, 1, 32'd100, 32'd2, 1, 1, "pushpop_full");
      for (int j = 1; j <= 16; j++)
         add(0, 1, 32'h0, (j < 15) ? 32'(j + 2) : ((j == 15) ? 32'd100 : 32'h0),
             0, (j < 16), "drain100");

      foreach (vecs[i]) begin
         step(vecs[i].push, vecs[i].pop, vecs[i].din);
         check(vecs[i].name, vecs[i].dout, vecs[i].full, vecs[i].pndng);
      end

      // Wrap-around: alternating push/pop of incrementing data
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 32'(32'h200 + i));
         check("wrap_push", 32'(32'h200 + i), 1'b0, 1'b1);
         step(1'b0, 1'b1, '0);
         check("wrap_pop", '0, 1'b0, 1'b0);
      end

      // Async reset mid-stream with 5 words queued
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(32'h10 + i));
      step(1'b0, 1'b0, '0);
      check("queued5", 32'h10, 1'b0, 1'b1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("reset_async", '0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 32'hA5A5_A5A5);
      check("post_reset_push", 32'hA5A5_A5A5, 1'b0, 1'b1);
      step(1'b0, 1'b1, '0);
      check("post_reset_pop", '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_flop_fifo

// File: doc/flop_fifo.md
# flop_fifo

Synchronous first-in/first-out buffer built entirely from flip-flops (no RAM macros), parameterized in data width and depth. It decouples a producer, which pushes words, from a consumer, which pops them. It reports `full` and `pndng` (data pending) status. The block is a leaf component and is instantiated directly by the surrounding datapath and by its unit bench.

## Interface
Parameters:
- `bits`, 32: data word width in bits (≥1).
- `depth`, 16: number of storage entries (≥2, power of two not required).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted).
- `Din` in `bits`: write data, sampled on the rising edge when `push` is accepted.
- `push` in 1: write request.
- `pop` in 1: read request; removes the current head word.
- `Dout` out `bits`: head (oldest) word, first-word-fall-through; 0 when empty.
- `full` out 1: 1 when occupancy == `depth`.
- `pndng` out 1: 1 when occupancy ≥ 1.

## Operation
- Storage: `depth` registers of `bits` width, plus a write pointer, a read pointer and an occupancy counter.
  - Pointers are `$clog2(depth)` bits wide and wrap from `depth-1` to 0 (modulo `depth`, valid for non-power-of-two depths).
  - The counter is `$clog2(depth+1)` bits wide.
- Accepted push = `push && (!full || pop)`. On an accepted push, `Din` is written to `mem[wr_ptr]` and `wr_ptr` advances.
- Accepted pop = `pop && pndng`. On an accepted pop, `rd_ptr` advances.
- Counter update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both are accepted, or when neither is.
- Boundary cases:
  - Push while full without pop: ignored. Data is dropped and the state is unchanged.
  - Push and pop while full: both occur, and `full` stays 1.
  - Pop while empty: ignored, with no underflow.
  - Push and pop while empty: only the push is accepted, so occupancy becomes 1.
- `Dout` = `mem[rd_ptr]` when `pndng`, else all-zero. It is combinational from the registered state.
- `full` and `pndng` are decoded combinationally from the counter.

## Timing
- Reset (`rst` = 0, asynchronous): pointers and counter clear to 0 immediately. As a result, `full` = 0, `pndng` = 0 and `Dout` = 0 without waiting for a clock edge.
  - Storage contents need not be cleared.
  - Reset during activity discards all queued data.
- Reset release is synchronous to `clk` by the integrating design. The first push is accepted on the first rising edge with `rst` = 1.
- Write latency: a word pushed at edge N is visible on `Dout` (if it is the head) and raises `pndng` right after edge N.
- Read: `Dout` holds the head before the edge. The pop at edge N presents the next word right after edge N.
- `full` rises right after the edge that writes the `depth`-th word, and falls right after the first accepted pop.

## Structure
- Shared package `fifo_pkg`: default constants `FIFO_BITS` = 32 and `FIFO_DEPTH` = 16.
- Sub-module `fifo_reg`: a `bits`-wide D register with load enable and asynchronous active-low clear. It is instantiated `depth` times in a generate loop.
- Read-side selection is a `depth`:1 mux indexed by `rd_ptr`. It is written inline as a combinational case/index.
- Expected size: 120–250 lines of RTL.

## Test plan
- Reset: assert `rst` = 0 mid-stream with 5 words queued → `pndng` = 0, `full` = 0 and `Dout` = 0 immediately; after release, a push of 0xA5A5A5A5 appears on `Dout`.
- Fill and drain: push 1..16 → `full` = 1 after the 16th; pop 16 times → `Dout` sequence 1..16 and `pndng` = 0 after the last pop.
- Overflow: with the FIFO full of 1..16, push 0xDEAD → ignored; pops return 1..16 and never 0xDEAD.
- Underflow: pop with the FIFO empty → no state change; a following push of 7 then pop returns 7.
- Simultaneous push and pop:
  - While full (push 100) → `full` stays 1 and the head advances; 100 is the last word returned.
  - While empty (push 5) → occupancy 1 and `Dout` = 5.
- Wrap-around: 40 cycles of alternating push/pop with incrementing data → pointers wrap at least twice; every output equals its input in order.
